// File: rtl/spi_target_pkg.sv
// Shared types and constants for the spi_target SPI responder.
package spi_target_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_target_state_t;

  localparam logic [SPI_BYTE_W-1:0] SPI_TARGET_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous FIFO feeding the spi_target transmit shifter.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module spi_target_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push_valid & ~w_full;
  assign w_pop   = i_pop & ~o_empty;

  assign o_push_ready = ~w_full;
  assign o_head       = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, oversampled in the clk domain.
// Define SPI_TARGET_UNDERRUN_CNT_EN to build the saturating underrun counter.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                    TX_DEPTH  = 4,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = SPI_TARGET_IDLE_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  input  logic                  ovr_clr,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [15:0]           underrun_cnt
);

  logic [2:0]            r_cs_sync;
  logic [2:0]            r_sclk_sync;
  logic [1:0]            r_mosi_sync;
  spi_target_state_t     r_state;
  spi_target_state_t     w_next_state;
  logic [2:0]            r_bit_cnt;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic [SPI_BYTE_W-2:0] r_rx_shift;
  logic                  r_miso_oe;
  logic [SPI_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_overrun;

  logic                  w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_mosi;
  logic                  w_active, w_load_tx, w_shift_tx, w_rx_shift, w_byte_done;
  logic                  w_fifo_empty, w_underrun;
  logic [SPI_BYTE_W-1:0] w_fifo_head, w_tx_byte, w_rx_byte;

  // Stage [1] is the synchronized level, stage [2] its previous value for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_sync   <= 3'b111;
      r_sclk_sync <= 3'b000;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs};
      r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
    end
  end

  assign w_cs_fall   = ~r_cs_sync[1] &  r_cs_sync[2];
  assign w_cs_rise   =  r_cs_sync[1] & ~r_cs_sync[2];
  assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
  assign w_mosi      =  r_mosi_sync[1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next_state = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A CS rise takes priority over any SCLK edge seen in the same cycle.
  assign w_active    = (r_state == ACTIVE) && !w_cs_rise;
  assign w_load_tx   = ((r_state == IDLE) && w_cs_fall) ||
                       (w_active && w_sclk_fall && (r_bit_cnt == 3'd0));
  assign w_shift_tx  = w_active && w_sclk_fall && (r_bit_cnt != 3'd0);
  assign w_rx_shift  = w_active && w_sclk_rise;
  assign w_byte_done = w_rx_shift && (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift, w_mosi};
  assign w_tx_byte   = w_fifo_empty ? IDLE_BYTE : w_fifo_head;
  assign w_underrun  = w_load_tx && w_fifo_empty;

  spi_target_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (tx_valid),
    .o_push_ready (tx_ready),
    .i_push_data  (tx_data),
    .i_pop        (w_load_tx),
    .o_head       (w_fifo_head),
    .o_empty      (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_miso_oe  <= 1'b0;
    end else begin
      if (w_load_tx) begin
        r_tx_shift <= w_tx_byte;
        r_miso_oe  <= 1'b1;
      end else if (w_shift_tx) begin
        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
      end else if ((r_state == ACTIVE) && w_cs_rise) begin
        r_miso_oe  <= 1'b0;
      end
      if (w_rx_shift) begin
        r_rx_shift <= w_rx_byte[SPI_BYTE_W-2:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end else if (!w_active) begin
        r_bit_cnt  <= '0;
      end
    end
  end

  // A completed byte is accepted when the holding register is free or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_byte_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_byte_done && r_rx_valid && !rx_ready) r_rx_overrun <= 1'b1;
      else if (ovr_clr)                           r_rx_overrun <= 1'b0;
    end
  end

  assign spi_miso    = r_miso_oe ? r_tx_shift[SPI_BYTE_W-1] : 1'b1;
  assign spi_miso_oe = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;

`ifdef SPI_TARGET_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                          r_underrun_cnt <= '0;
    else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  logic w_unused_underrun;
  assign w_unused_underrun = w_underrun;
  assign underrun_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a host model drives SPI frames while
// expected MISO/RX bytes are queued at stimulus time and compared on output.
module tb_spi_target;

  localparam int TX_DEPTH = 4;
  localparam int HALF     = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs, spi_sclk, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_overrun, ovr_clr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] underrun_cnt;

  int errors = 0;
  int checks = 0;
  int exp_subs = 0;

  logic [7:0] fifo_model [$];
  logic [7:0] exp_miso   [$];
  logic [7:0] rx_exp     [$];
  logic [7:0] h_mosi     [$];

  always #5 clk = ~clk;

  spi_target #(.TX_DEPTH(TX_DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_cs       (spi_cs),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .ovr_clr      (ovr_clr),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .underrun_cnt (underrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_underrun();
`ifdef SPI_TARGET_UNDERRUN_CNT_EN
    return (exp_subs > 16'hFFFF) ? 16'hFFFF : 16'(exp_subs);
`else
    return 16'h0000;
`endif
  endfunction

  // Consumer side of the scoreboard: every handshake pops one expected byte.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      check("rx_pending", 32'(rx_exp.size() > 0), 1);
      if (rx_exp.size() > 0) check("rx_data", rx_data, rx_exp.pop_front());
    end
  end

  task automatic push(input logic [7:0] d);
    check("tx_ready", tx_ready, 32'(fifo_model.size() < TX_DEPTH));
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
    if (fifo_model.size() < TX_DEPTH) fifo_model.push_back(d);
  endtask

  // Host frame of nbits SCLK rises; SCLK is left high until after CS rises.
  task automatic spi_frame(input int nbits);
    int         loads;
    logic [7:0] got;
    loads = 1 + (nbits - 1) / 8;
    for (int k = 0; k < loads; k++) begin
      if (fifo_model.size() > 0) exp_miso.push_back(fifo_model.pop_front());
      else begin
        exp_miso.push_back(8'hFF);
        exp_subs++;
      end
    end
    got    = '0;
    spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i / 8 < h_mosi.size()) ? h_mosi[i / 8][7 - (i % 8)] : 1'b0;
      wait_clks(HALF);
      if (i == 0) check("miso_oe_active", spi_miso_oe, 1);
      got      = {got[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clks(HALF);
      if (i % 8 == 7) begin
        check("miso_avail", 32'(exp_miso.size() > 0), 1);
        if (exp_miso.size() > 0) check("miso_byte", got, exp_miso.pop_front());
      end
      if (i != nbits - 1) spi_sclk = 1'b0;
    end
    spi_cs = 1'b1;
    wait_clks(HALF);
    spi_sclk = 1'b0;
    wait_clks(HALF);
    check("miso_idle", spi_miso, 1);
    check("miso_oe_idle", spi_miso_oe, 0);
    exp_miso.delete();
    h_mosi.delete();
  endtask

  task automatic drain_rx();
    int t = 0;
    while (rx_exp.size() != 0 && t < 200) begin
      wait_clks(1);
      t++;
    end
    check("rx_drain", rx_exp.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 1);
    check({tag, "_oe"}, spi_miso_oe, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_overrun"}, rx_overrun, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_underrun"}, underrun_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    rx_ready = 1'b1; ovr_clr = 1'b0; tx_data = '0; tx_valid = 1'b0;
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(4);

    // Queued response bytes and two received bytes.
    push(8'hA5);
    push(8'h3C);
    h_mosi = '{8'h12, 8'h34};
    rx_exp.push_back(8'h12);
    rx_exp.push_back(8'h34);
    spi_frame(16);
    drain_rx();
    check("underrun_t1", underrun_cnt, exp_underrun());

    // Empty FIFO: every byte is an IDLE_BYTE substitution.
    h_mosi = '{8'h81, 8'h7E, 8'hF0};
    rx_exp.push_back(8'h81);
    rx_exp.push_back(8'h7E);
    rx_exp.push_back(8'hF0);
    spi_frame(24);
    drain_rx();
    check("underrun_t2", underrun_cnt, exp_underrun());

    // Consumer stalled: second byte is dropped and overrun latches.
    rx_ready = 1'b0;
    h_mosi = '{8'h01, 8'h02};
    rx_exp.push_back(8'h01);
    spi_frame(16);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h01);
    check("ovr_flag", rx_overrun, 1);
    ovr_clr = 1'b1;
    wait_clks(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", rx_overrun, 0);
    rx_ready = 1'b1;
    drain_rx();

    // Aborted partial byte, then a full byte.
    h_mosi = '{8'hAA};
    spi_frame(5);
    h_mosi = '{8'hC3};
    rx_exp.push_back(8'hC3);
    spi_frame(8);
    drain_rx();
    check("underrun_t4", underrun_cnt, exp_underrun());

    // FIFO full: fifth push is refused.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    h_mosi = '{8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h23};
    foreach (h_mosi[k]) rx_exp.push_back(h_mosi[k]);
    spi_frame(40);
    drain_rx();
    check("underrun_t5", underrun_cnt, exp_underrun());

    // Reset in the middle of a byte flushes the FIFO.
    push(8'h66);
    push(8'h77);
    spi_cs = 1'b0;
    wait_clks(HALF);
    repeat (3) begin
      spi_sclk = 1'b1; wait_clks(HALF);
      spi_sclk = 1'b0; wait_clks(HALF);
    end
    check("pre_reset_oe", spi_miso_oe, 1);
    rst = 1'b1;
    spi_cs = 1'b1;
    wait_clks(1);
    check_reset_outputs("midreset");
    fifo_model.delete();
    exp_subs = 0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);
    h_mosi = '{8'h5C};
    rx_exp.push_back(8'h5C);
    spi_frame(8);
    drain_rx();
    check("underrun_t6", underrun_cnt, exp_underrun());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

Synthesizable SPI target (mode 0, MSB first) that answers the chip's SPI host on the `spi_cs`/`spi_sclk`/`spi_mosi`/`spi_miso` pins. It oversamples the SPI pins in the system clock domain and delivers received bytes on a valid/ready port. Response bytes are served from a small transmit FIFO. It is the responder end of the SD/SPI link and replaces the simple MOSI-to-MISO loopback in chip-level simulation and FPGA test builds.

## Interface
- `TX_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `IDLE_BYTE`, 8'hFF: byte shifted out when the FIFO is empty at a byte boundary.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `spi_cs` in 1: chip select, active low, asynchronous to `clk`.
- `spi_sclk` in 1: SPI clock, asynchronous to `clk`.
- `spi_mosi` in 1: host-to-target data.
- `spi_miso` out 1: target-to-host data.
- `spi_miso_oe` out 1: MISO output enable; high while CS is asserted.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts. Transfer occurs when `rx_valid & rx_ready`.
- `rx_overrun` out 1: sticky; a completed byte was dropped.
- `ovr_clr` in 1: clears `rx_overrun`.
- `tx_data` in 8: byte to push.
- `tx_valid` in 1: push request.
- `tx_ready` out 1: FIFO not full. Push occurs when `tx_valid & tx_ready`.
- `underrun_cnt` out 16: count of `IDLE_BYTE` substitutions; see Configuration.

## Operation
- `spi_cs`, `spi_sclk` and `spi_mosi` each pass through a 2-flop synchronizer. A third register on CS and SCLK provides edge detection. MOSI travels through identical stages, so it stays aligned with SCLK.
- State IDLE (synchronized CS high):
  - `spi_miso_oe`=0, `spi_miso`=1, bit counter=0.
  - On CS falling edge → ACTIVE. Pop the FIFO head into the tx shift register, or load `IDLE_BYTE` if the FIFO is empty (underrun). Drive `spi_miso`=bit 7 of the loaded byte and set `spi_miso_oe`=1.
- State ACTIVE:
  - SCLK rise: shift MOSI into the rx shift register LSB and increment the 3-bit bit counter, which wraps 7→0.
  - Byte complete (the rise that wraps 7→0):
    - If the holding register is empty, or is being consumed in the same cycle, load it and assert `rx_valid`.
    - Otherwise drop the new byte, keep the old one, and set `rx_overrun`.
  - SCLK fall with counter=0: load the next tx byte (pop, or `IDLE_BYTE` on underrun). `spi_miso` = its bit 7.
  - SCLK fall with counter≠0: shift the tx register left; `spi_miso` = next bit.
  - CS rising edge → IDLE. Any partial rx byte is discarded. A tx byte already popped is lost and is not re-queued.
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - When full, `tx_ready`=0 and a push is ignored.
  - When empty, a pop yields `IDLE_BYTE`. A push arriving in the same cycle is not bypassed to the shifter; it lands in the FIFO.
- `rx_overrun`: if `ovr_clr` and a new overrun occur in the same cycle, the set wins.
- SCLK edges while in IDLE are ignored.

## Timing
- Reset values:
  - `spi_miso`=1, `spi_miso_oe`=0.
  - `rx_valid`=0, `rx_data`=0, `rx_overrun`=0.
  - `tx_ready`=1, FIFO empty.
  - `underrun_cnt`=0, state IDLE, all synchronizer flops take their idle values (CS=1, SCLK=0).
- Reset asserted mid-transfer: abort immediately and flush the FIFO.
- Pin-to-action latency is 3 `clk` edges after the pin change is first sampled, i.e. ≤4 cycles.
  - `rx_valid` rises ≤4 cycles after the 8th SCLK rise.
  - `spi_miso` updates ≤4 cycles after an SCLK fall.
- Required host timing:
  - SCLK high and low phases ≥6 `clk` periods.
  - CS falling edge to first SCLK rise ≥6 periods.
  - CS high between frames ≥3 periods.
- `rx_valid` stays high until a handshake. `rx_data` is stable while `rx_valid`=1.

## Configuration
- `SPI_TARGET_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` increments on every `IDLE_BYTE` substitution and saturates at 16'hFFFF.
  - It clears only on `rst`.
- Not defined: `underrun_cnt` is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Structure
- `spi_target_pkg`: `SPI_BYTE_W`=8, state enum `spi_target_state_t` {IDLE, ACTIVE}, default `IDLE_BYTE` constant.
- Sub-module `spi_target_fifo`: synchronous FIFO parameterized by width and depth.
  - Ports: `clk`, `rst`, push valid/ready, pop request, head data, empty.
  - Pointers carry one extra wrap bit for full/empty detection.
- `spi_target` holds the synchronizers, edge detect, FSM, both shifters, the rx holding register and the optional counter.

## Test plan
- Push 8'hA5 and 8'h3C, then run a 2-byte frame with MOSI bytes 8'h12 and 8'h34 → MISO shows A5 then 3C; `rx_data` delivers 12 then 34; `underrun_cnt`=0.
- Empty FIFO, 3-byte frame → MISO shows FF FF FF; `underrun_cnt`=3 with the macro defined, 0 without it.
- Hold `rx_ready`=0 across 2 received bytes (8'h01, 8'h02) → `rx_data`=01 and `rx_overrun`=1; `ovr_clr` then clears the flag.
- Deassert CS after 5 SCLK rises, then send a full byte 8'hC3 → only C3 is delivered, and the partial byte is never reported.
- Push 5 bytes with `TX_DEPTH`=4 → `tx_ready` falls after the 4th push and the 5th is ignored; the frame returns only the first 4 bytes, then FF.
- Assert `rst` mid-byte → all outputs return to their reset values on the next cycle, and the next frame returns FF.
